csa_pipe: RTL

Parametrised, pipelined carry-skip adder/subtractor. It generalises the team's 4-bit carry-skip adder to WIDTH bits split into NBLK = WIDTH/BLOCK skip blocks, with one block resolved per pipeline stage. Operands enter through a valid/ready handshake, and results leave the same way with full backpressure. It adds subtraction, signed overflow and throughput of one operation per cycle. It sits between operand-producing datapath logic and any consumer that needs a registered sum.

---
 rtl/csa_pkg.sv | 15 +
 rtl/csa_block.sv | 31 +++
 rtl/csa_pipe.sv | 109 ++++++++++
 3 files changed

// File: rtl/csa_pkg.sv
// Shared helpers for the pipelined carry-skip adder: block count and the
// per-stage control flags carried alongside the datapath vectors.
package csa_pkg;

  function automatic int nblk(input int width, input int block);
    return width / block;
  endfunction

  typedef struct packed {
    logic valid;
    logic carry;
    logic msb;
  } csa_flags_t;

endpackage

// File: rtl/csa_block.sv
// One combinational carry-skip block: BLOCK-bit ripple plus a skip mux that
// forwards cin when every bit propagates.
module csa_block #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [BLOCK-1:0] p;
  logic [BLOCK:0]   c;

  assign p = a ^ b;

  always_comb begin
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < BLOCK; i++) begin
      c[i+1] = (a[i] & b[i]) | (p[i] & c[i]);
    end
  end

  assign s     = p ^ c[BLOCK-1:0];
  assign cout  = (&p) ? cin : c[BLOCK];
  assign c_msb = c[BLOCK-1];

endmodule

// File: rtl/csa_pipe.sv
// Pipelined carry-skip adder/subtractor: one skip block resolved per stage,
// valid/ready on both sides with bubble-collapsing backpressure.
module csa_pipe
  import csa_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int NBLK = nblk(WIDTH, BLOCK);

  if ((WIDTH % BLOCK) != 0 || WIDTH < BLOCK) begin : g_bad_width
    $error("csa_pipe: WIDTH must be a non-zero multiple of BLOCK");
  end

  // Operand vectors are kept shifted so the next block always sits at [BLOCK-1:0].
  typedef struct packed {
    csa_flags_t       flags;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] a_rem;
    logic [WIDTH-1:0] b_rem;
  } stage_t;

  stage_t           stage_q  [NBLK];
  stage_t           stage_d  [NBLK];
  logic             adv      [NBLK];
  logic             src_valid[NBLK];
  logic             src_carry[NBLK];
  logic [WIDTH-1:0] src_a    [NBLK];
  logic [WIDTH-1:0] src_b    [NBLK];
  logic [WIDTH-1:0] src_sum  [NBLK];
  logic [BLOCK-1:0] blk_s    [NBLK];
  logic             blk_cout [NBLK];
  logic             blk_cmsb [NBLK];

  for (genvar gi = 0; gi < NBLK; gi++) begin : g_stage
    if (gi == 0) begin : g_src_in
      assign src_valid[gi] = in_valid;
      assign src_carry[gi] = cin ^ sub;
      assign src_a[gi]     = a;
      assign src_b[gi]     = b ^ {WIDTH{sub}};
      assign src_sum[gi]   = '0;
    end else begin : g_src_prev
      assign src_valid[gi] = stage_q[gi-1].flags.valid;
      assign src_carry[gi] = stage_q[gi-1].flags.carry;
      assign src_a[gi]     = stage_q[gi-1].a_rem;
      assign src_b[gi]     = stage_q[gi-1].b_rem;
      assign src_sum[gi]   = stage_q[gi-1].sum;
    end

    csa_block #(.BLOCK(BLOCK)) u_blk (
      .a     (src_a[gi][BLOCK-1:0]),
      .b     (src_b[gi][BLOCK-1:0]),
      .cin   (src_carry[gi]),
      .s     (blk_s[gi]),
      .cout  (blk_cout[gi]),
      .c_msb (blk_cmsb[gi])
    );
  end

  always_comb begin
    adv = '{default: 1'b0};
    adv[NBLK-1] = !stage_q[NBLK-1].flags.valid || out_ready;
    for (int k = NBLK - 2; k >= 0; k--) begin
      adv[k] = !stage_q[k].flags.valid || adv[k+1];
    end

    for (int k = 0; k < NBLK; k++) begin
      stage_d[k] = stage_q[k];
      if (adv[k]) begin
        stage_d[k].flags.valid = src_valid[k];
        stage_d[k].flags.carry = blk_cout[k];
        stage_d[k].flags.msb   = blk_cmsb[k];
        stage_d[k].sum         = src_sum[k] | (WIDTH'(blk_s[k]) << (k * BLOCK));
        stage_d[k].a_rem       = src_a[k] >> BLOCK;
        stage_d[k].b_rem       = src_b[k] >> BLOCK;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '{default: '0};
    end else begin
      stage_q <= stage_d;
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = stage_q[NBLK-1].flags.valid;
  assign s         = stage_q[NBLK-1].sum;
  assign cout      = stage_q[NBLK-1].flags.carry;
  assign ovf       = stage_q[NBLK-1].flags.msb ^ stage_q[NBLK-1].flags.carry;

endmodule
